// File: rtl/nextasic_serial_pkg.sv
// Link-level constants and FSM encoding shared by the serial transmitter and receiver.
// No timing or flow-control behaviour of its own.
package nextasic_serial_pkg;

  localparam int   FRAME_BITS  = 40;
  localparam logic START_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b0;
  localparam int   MIN_GAP     = 2;
  localparam int   BIT_CNT_W   = 6;
  localparam int   GAP_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/serial_transmitter_if.sv
// Producer-side valid/ready word handshake into the serial transmitter (zero latency).
// Transfer when tx_valid & tx_ready; the producer holds tx_data while tx_ready is low.
interface serial_transmitter_if;
  import nextasic_serial_pkg::*;

  logic [FRAME_BITS-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/serial_transmitter.sv
// Serialises 40-bit words as start bit + LSB-first data + IDLE_GAP zeros; start bit 1 cycle after accept.
// A one-word holding buffer queues the next frame; tx_ready drops while it is full.
module serial_transmitter
  import nextasic_serial_pkg::*;
#(
  parameter int IDLE_GAP = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  serial_transmitter_if.slave tx_if,
  output logic                so,
  output logic                busy,
  output logic                frame_done,
  output logic [CNT_W-1:0]    frames_sent
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_START = ST_START;
  localparam logic [1:0] S_DATA  = ST_DATA;
  localparam logic [1:0] S_GAP   = ST_GAP;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(IDLE_GAP - 1);

  generate
    if (IDLE_GAP < MIN_GAP || IDLE_GAP > 15) begin : g_bad_gap
      $fatal(1, "serial_transmitter: IDLE_GAP must be in 2..15");
    end
  endgenerate

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic                  so_q, so_d;
  logic                  frame_done_q, frame_done_d;
  logic [CNT_W-1:0]      frames_sent_q, frames_sent_d;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    so_d          = so_q;
    frame_done_d  = 1'b0;
    frames_sent_d = frames_sent_q;

    // Accept only into an empty buffer, so the move below never collides with a write.
    if (tx_if.tx_valid && !hold_vld_q) begin
      hold_d     = tx_if.tx_data;
      hold_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (hold_vld_q) begin
          state_d    = S_START;
          shift_d    = hold_q;
          hold_vld_d = 1'b0;
          so_d       = START_LEVEL;
        end
      end
      S_START: begin
        state_d   = S_DATA;
        so_d      = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
      end
      S_DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d       = S_GAP;
          so_d          = IDLE_LEVEL;
          gap_cnt_d     = '0;
          frame_done_d  = 1'b1;
          frames_sent_d = frames_sent_q + 1'b1;
        end else begin
          so_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (hold_vld_q) begin
            state_d    = S_START;
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
            so_d       = START_LEVEL;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      so_q          <= IDLE_LEVEL;
      frame_done_q  <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_vld_q    <= hold_vld_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      so_q          <= so_d;
      frame_done_q  <= frame_done_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign tx_if.tx_ready = ~hold_vld_q;
  assign so             = so_q;
  assign busy           = (state_q != S_IDLE) | hold_vld_q;
  assign frame_done     = frame_done_q;
  assign frames_sent    = frames_sent_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench: two transmitters (IDLE_GAP=4/CNT_W=16 and IDLE_GAP=2/CNT_W=4) each feeding a
// behavioural frame receiver; received words are scored against a queue filled at accept time.
module tb_serial_transmitter;

  logic clk = 1'b0;
  logic rst1_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  serial_transmitter_if if1();
  serial_transmitter_if if2();

  logic        so1, busy1, fd1;
  logic [15:0] fs1;
  logic        so2, busy2, fd2;
  logic [3:0]  fs2;

  serial_transmitter #(.IDLE_GAP(4), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset_n(rst1_n), .tx_if(if1.slave),
    .so(so1), .busy(busy1), .frame_done(fd1), .frames_sent(fs1));

  serial_transmitter #(.IDLE_GAP(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset_n(rst2_n), .tx_if(if2.slave),
    .so(so2), .busy(busy2), .frame_done(fd2), .frames_sent(fs2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver models: hunt for a 1, then shift in 40 bits LSB first.
  logic        r1_on, r2_on;
  int          r1_cnt, r2_cnt;
  logic [39:0] r1_sh, r2_sh;
  logic [39:0] rx_words1 [0:63];
  logic [39:0] rx_words2 [0:63];
  int          rx_cnt1 = 0, rx_cnt2 = 0;
  int          start_cyc1 [0:63];
  int          start_cyc2 [0:63];
  int          n_start1 = 0, n_start2 = 0;

  always @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) begin
      r1_on <= 1'b0; r1_cnt <= 0; r1_sh <= '0;
    end else if (!r1_on) begin
      if (so1) begin
        r1_on <= 1'b1; r1_cnt <= 0;
        start_cyc1[n_start1] <= cyc; n_start1 <= n_start1 + 1;
      end
    end else begin
      r1_sh  <= {so1, r1_sh[39:1]};
      r1_cnt <= r1_cnt + 1;
      if (r1_cnt == 39) begin
        r1_on <= 1'b0;
        rx_words1[rx_cnt1] <= {so1, r1_sh[39:1]};
        rx_cnt1 <= rx_cnt1 + 1;
      end
    end
  end

  always @(posedge clk or negedge rst2_n) begin
    if (!rst2_n) begin
      r2_on <= 1'b0; r2_cnt <= 0; r2_sh <= '0;
    end else if (!r2_on) begin
      if (so2) begin
        r2_on <= 1'b1; r2_cnt <= 0;
        start_cyc2[n_start2] <= cyc; n_start2 <= n_start2 + 1;
      end
    end else begin
      r2_sh  <= {so2, r2_sh[39:1]};
      r2_cnt <= r2_cnt + 1;
      if (r2_cnt == 39) begin
        r2_on <= 1'b0;
        rx_words2[rx_cnt2] <= {so2, r2_sh[39:1]};
        rx_cnt2 <= rx_cnt2 + 1;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int rd1 = 0, rd2 = 0;
  logic [39:0] exp1 [$];
  logic [39:0] exp2 [$];

  typedef struct {
    logic [39:0] data;
    int          exp_frames;
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer1(input logic [39:0] d);
    logic rdy;
    bit   done = 0;
    if1.tx_data  = d;
    if1.tx_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      rdy = if1.tx_ready;
      tick();
      if (rdy) done = 1;
    end
    if1.tx_valid = 1'b0;
    if (done) exp1.push_back(d);
    else begin n_chk++; n_fail++; $display("FAIL offer1_timeout: tx_ready never 1, word %h", d); end
  endtask

  task automatic offer2(input logic [39:0] d);
    logic rdy;
    bit   done = 0;
    if2.tx_data  = d;
    if2.tx_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      rdy = if2.tx_ready;
      tick();
      if (rdy) done = 1;
    end
    if2.tx_valid = 1'b0;
    if (done) exp2.push_back(d);
    else begin n_chk++; n_fail++; $display("FAIL offer2_timeout: tx_ready never 1, word %h", d); end
  endtask

  task automatic rx1_check(input string nm);
    for (int t = 0; t < 300 && rx_cnt1 <= rd1; t++) tick();
    if (rx_cnt1 <= rd1 || exp1.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no word received (rx %0d, pending %0d)", nm, rx_cnt1, exp1.size());
      if (exp1.size() != 0) void'(exp1.pop_front());
    end else begin
      chk(nm, rx_words1[rd1], exp1.pop_front());
      rd1++;
    end
  endtask

  task automatic rx2_check(input string nm);
    for (int t = 0; t < 300 && rx_cnt2 <= rd2; t++) tick();
    if (rx_cnt2 <= rd2 || exp2.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no word received (rx %0d, pending %0d)", nm, rx_cnt2, exp2.size());
      if (exp2.size() != 0) void'(exp2.pop_front());
    end else begin
      chk(nm, rx_words2[rd2], exp2.pop_front());
      rd2++;
    end
  endtask

  task automatic wait_idle1();
    for (int t = 0; t < 300 && busy1; t++) tick();
  endtask

  initial begin
    logic [39:0] bits;
    logic [39:0] w;
    int s;

    if1.tx_valid = 1'b0; if1.tx_data = '0;
    if2.tx_valid = 1'b0; if2.tx_data = '0;
    vecs[0] = '{40'h0000000000, 4};
    vecs[1] = '{40'hFFFFFFFFFF, 5};
    vecs[2] = '{40'h5555555555, 6};

    #22;
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    #1;
    chk("reset_so", {39'd0, so1}, 40'd0);
    chk("reset_tx_ready", {39'd0, if1.tx_ready}, 40'd1);
    chk("reset_busy", {39'd0, busy1}, 40'd0);
    chk("reset_frame_done", {39'd0, fd1}, 40'd0);
    chk("reset_frames_sent", {24'd0, fs1}, 40'd0);
    chk("reset2_frames_sent", {36'd0, fs2}, 40'd0);
    tick();

    // Single frame with cycle-exact line and status checks.
    offer1(40'hA5F09C3E12);
    tick();
    chk("t1_start_bit", {39'd0, so1}, 40'd1);
    for (int k = 0; k < 40; k++) begin
      tick();
      bits[k] = so1;
    end
    chk("t1_so_bits", bits, 40'hA5F09C3E12);
    chk("t1_fd_before", {39'd0, fd1}, 40'd0);
    tick();
    chk("t1_fd_pulse", {39'd0, fd1}, 40'd1);
    chk("t1_so_gap", {39'd0, so1}, 40'd0);
    chk("t1_frames_sent", {24'd0, fs1}, 40'd1);
    tick();
    chk("t1_fd_after", {39'd0, fd1}, 40'd0);
    tick(); tick();
    chk("t1_busy_in_gap", {39'd0, busy1}, 40'd1);
    tick();
    chk("t1_busy_after_gap", {39'd0, busy1}, 40'd0);
    rx1_check("t1_rx_word");

    // Back-to-back with tx_valid held across both words.
    s = n_start1;
    offer1(40'h0000000001);
    chk("t2_ready_low_hold_full", {39'd0, if1.tx_ready}, 40'd0);
    offer1(40'h8000000000);
    chk("t2_ready_low_2nd", {39'd0, if1.tx_ready}, 40'd0);
    rx1_check("t2_rx_first");
    rx1_check("t2_rx_second");
    chk("t2_start_spacing", 40'(start_cyc1[s+1] - start_cyc1[s]), 40'd45);
    chk("t2_frames_sent", {24'd0, fs1}, 40'd3);

    for (int i = 0; i < 3; i++) begin
      offer1(vecs[i].data);
      rx1_check($sformatf("t3_rx_vec%0d", i));
      chk($sformatf("t3_frames_vec%0d", i), {24'd0, fs1}, 40'(vecs[i].exp_frames));
    end

    // Reset asserted while data bit 20 is on the line.
    wait_idle1();
    offer1(40'hDEADBEEF00);
    repeat (22) tick();
    #2;
    rst1_n = 1'b0;
    #1;
    chk("t4_so_reset", {39'd0, so1}, 40'd0);
    chk("t4_ready_reset", {39'd0, if1.tx_ready}, 40'd1);
    chk("t4_frames_reset", {24'd0, fs1}, 40'd0);
    chk("t4_busy_reset", {39'd0, busy1}, 40'd0);
    void'(exp1.pop_front());
    #20;
    rst1_n = 1'b1;
    tick();
    offer1(40'h123456789A);
    rx1_check("t4_rx_after_reset");
    chk("t4_frames_after", {24'd0, fs1}, 40'd1);
    chk("t4_rx_count", 40'(rx_cnt1), 40'(rd1));

    // Minimum-gap instance: three back-to-back random words.
    s = n_start2;
    for (int i = 0; i < 3; i++) begin
      w = {8'($urandom), 32'($urandom)};
      offer2(w);
    end
    for (int i = 0; i < 3; i++) rx2_check($sformatf("t5_rx%0d", i));
    chk("t5_spacing_01", 40'(start_cyc2[s+1] - start_cyc2[s]), 40'd43);
    chk("t5_spacing_12", 40'(start_cyc2[s+2] - start_cyc2[s+1]), 40'd43);
    chk("t5_frames_sent", {36'd0, fs2}, 40'd3);

    // 4-bit frames_sent on this instance wraps after 16 frames.
    for (int i = 0; i < 12; i++) begin
      w = {8'($urandom), 32'($urandom)};
      offer2(w);
    end
    for (int i = 0; i < 12; i++) rx2_check($sformatf("t6_rx%0d", i));
    chk("t6_frames_15", {36'd0, fs2}, 40'd15);
    offer2(40'hC3C3C3C3C3);
    rx2_check("t6_rx_16th");
    chk("t6_frames_wrap", {36'd0, fs2}, 40'd0);
    offer2(40'h0F0F0F0F0F);
    rx2_check("t6_rx_17th");
    chk("t6_frames_after_wrap", {36'd0, fs2}, 40'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
